// File: rtl/hood_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hood_pkg
// Description : Shared FSM state encodings, default durations and a
//               time-conversion helper for the range-hood mode controller.
// Revision    : 1.0 - initial release
// ============================================================================
package hood_pkg;

    // FSM state encodings
    localparam logic [2:0] ST_STANDBY    = 3'd0;
    localparam logic [2:0] ST_ARMED      = 3'd1;
    localparam logic [2:0] ST_RUN        = 3'd2;
    localparam logic [2:0] ST_BOOST      = 3'd3;
    localparam logic [2:0] ST_EXIT_DELAY = 3'd4;
    localparam logic [2:0] ST_CLEANING   = 3'd5;

    // Default timing and sizing
    localparam int DEF_CLK_HZ       = 100_000_000;
    localparam int DEF_NUM_SPEEDS   = 3;
    localparam int DEF_BOOST_SEC    = 60;
    localparam int DEF_EXIT_SEC     = 60;
    localparam int DEF_CLEAN_SEC    = 180;
    localparam int DEF_DEBOUNCE_CYC = 1_000_000;

    // Hours/minutes folded into total minutes (31*60+63 fits in 11 bits)
    function automatic logic [10:0] to_minutes(input logic [4:0] hours,
                                               input logic [5:0] minutes);
        return (11'(hours) * 11'd60) + 11'(minutes);
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchroniser, persistence debounce and rising-edge
//               detector; emits a single-cycle pulse per accepted press.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic btn_raw,
    output logic pulse
);

    localparam int             CW      = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYC - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic          stable;
    logic [CW-1:0] cnt;

    // Synchronise, then accept a new level only after it persists DEBOUNCE_CYC cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            stable  <= 1'b0;
            cnt     <= '0;
            pulse   <= 1'b0;
        end else if (clear) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            stable  <= 1'b0;
            cnt     <= '0;
            pulse   <= 1'b0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
            pulse   <= 1'b0;
            if (sync_q2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync_q2;
                cnt    <= '0;
                pulse  <= sync_q2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hood_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hood_mode_ctrl
// Description : Range-hood fan mode controller: menu/speed/clean keys, timed
//               boost, delayed-off and self-clean states, fan-on work timer
//               and cleaning reminder.
// Revision    : 1.0 - initial release
// ============================================================================
module hood_mode_ctrl
    import hood_pkg::*;
#(
    parameter int CLK_HZ       = DEF_CLK_HZ,
    parameter int NUM_SPEEDS   = DEF_NUM_SPEEDS,
    parameter int BOOST_SEC    = DEF_BOOST_SEC,
    parameter int EXIT_SEC     = DEF_EXIT_SEC,
    parameter int CLEAN_SEC    = DEF_CLEAN_SEC,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  power_state,
    input  logic                  menu_btn,
    input  logic [NUM_SPEEDS-1:0] speed_btn,
    input  logic                  clean_btn,
    input  logic [4:0]            remind_hours,
    input  logic [5:0]            remind_minutes,
    output logic [NUM_SPEEDS-1:0] mode,
    output logic                  cleaning,
    output logic                  countdown,
    output logic [15:0]           remain_sec,
    output logic [4:0]            work_hours,
    output logic [5:0]            work_minutes,
    output logic [5:0]            work_seconds,
    output logic                  cleaning_reminder
);

    localparam int            PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [2:0]    TOP_LVL   = 3'(NUM_SPEEDS - 1);

    logic [2:0]    state;
    logic [2:0]    level;
    logic [15:0]   remain;
    logic [PW-1:0] presc;
    logic          boost_used;
    logic [PW-1:0] work_presc;
    logic          reminder;

    logic          menu_pulse;
    logic          speed_onehot;
    logic [2:0]    speed_idx;
    logic          timed;
    logic          sec_tick;
    logic          timed_done;
    logic          enter_clean;
    logic          counting;
    logic          work_sat;

    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_menu_db (
        .clk     (clk),
        .rst_n   (reset),
        .clear   (~power_state),
        .btn_raw (menu_btn),
        .pulse   (menu_pulse)
    );

    // Decode the speed keys into a validity flag and a level index
    always_comb begin
        speed_onehot = $onehot(speed_btn);
        speed_idx    = 3'd0;
        for (int k = 0; k < NUM_SPEEDS; k++) begin
            if (speed_btn[k]) speed_idx = 3'(k);
        end
    end

    // Timed-state and work-timer qualifiers
    always_comb begin
        timed       = (state == ST_BOOST) || (state == ST_EXIT_DELAY) || (state == ST_CLEANING);
        sec_tick    = (presc == PRESC_MAX);
        timed_done  = timed && sec_tick && (remain == 16'd1);
        enter_clean = power_state && (state == ST_ARMED) && (speed_btn == '0) && clean_btn;
        counting    = power_state &&
                      ((state == ST_RUN) || (state == ST_BOOST) || (state == ST_EXIT_DELAY));
        work_sat    = (work_hours == 5'd31) && (work_minutes == 6'd59) && (work_seconds == 6'd59);
    end

    // Mode FSM with per-state countdown; power-off overrides everything
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_STANDBY;
            level      <= 3'd0;
            remain     <= 16'd0;
            presc      <= '0;
            boost_used <= 1'b0;
        end else if (!power_state) begin
            state      <= ST_STANDBY;
            level      <= 3'd0;
            remain     <= 16'd0;
            presc      <= '0;
            boost_used <= 1'b0;
        end else begin
            if (timed) begin
                presc <= sec_tick ? '0 : presc + PW'(1);
                if (sec_tick) remain <= remain - 16'd1;
            end
            case (state)
                ST_STANDBY: begin
                    if (menu_pulse) state <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (speed_onehot) begin
                        if (speed_idx == TOP_LVL) begin
                            // A second boost in the same power session is ignored
                            if (!boost_used) begin
                                state      <= ST_BOOST;
                                level      <= TOP_LVL;
                                boost_used <= 1'b1;
                                remain     <= 16'(BOOST_SEC);
                                presc      <= '0;
                            end
                        end else begin
                            state <= ST_RUN;
                            level <= speed_idx;
                        end
                    end else if (enter_clean) begin
                        state  <= ST_CLEANING;
                        remain <= 16'(CLEAN_SEC);
                        presc  <= '0;
                    end
                end
                ST_RUN: begin
                    if (menu_pulse) begin
                        state <= ST_STANDBY;
                    end else if (speed_onehot && (speed_idx != TOP_LVL)) begin
                        level <= speed_idx;
                    end
                end
                ST_BOOST: begin
                    if (timed_done) begin
                        state  <= ST_RUN;
                        level  <= TOP_LVL - 3'd1;
                        remain <= 16'd0;
                    end else if (menu_pulse) begin
                        state  <= ST_EXIT_DELAY;
                        remain <= 16'(EXIT_SEC);
                        presc  <= '0;
                    end
                end
                ST_EXIT_DELAY: begin
                    if (timed_done) state <= ST_STANDBY;
                end
                ST_CLEANING: begin
                    if (timed_done) state <= ST_STANDBY;
                end
                default: begin
                    state <= ST_STANDBY;
                end
            endcase
        end
    end

    // Fan-on work timer (saturating) and cleaning reminder
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            work_presc   <= '0;
            work_hours   <= 5'd0;
            work_minutes <= 6'd0;
            work_seconds <= 6'd0;
            reminder     <= 1'b0;
        end else if (enter_clean) begin
            work_presc   <= '0;
            work_hours   <= 5'd0;
            work_minutes <= 6'd0;
            work_seconds <= 6'd0;
            reminder     <= 1'b0;
        end else begin
            if (counting) begin
                if (work_presc == PRESC_MAX) begin
                    work_presc <= '0;
                    if (!work_sat) begin
                        if (work_seconds == 6'd59) begin
                            work_seconds <= 6'd0;
                            if (work_minutes == 6'd59) begin
                                work_minutes <= 6'd0;
                                work_hours   <= work_hours + 5'd1;
                            end else begin
                                work_minutes <= work_minutes + 6'd1;
                            end
                        end else begin
                            work_seconds <= work_seconds + 6'd1;
                        end
                    end
                end else begin
                    work_presc <= work_presc + PW'(1);
                end
            end
            if ((state == ST_STANDBY) &&
                (to_minutes(remind_hours, remind_minutes) != 11'd0) &&
                (to_minutes(work_hours, work_minutes) >= to_minutes(remind_hours, remind_minutes))) begin
                reminder <= 1'b1;
            end
        end
    end

    // Outputs decoded from the registered state
    always_comb begin
        mode = '0;
        case (state)
            ST_RUN, ST_BOOST: mode = NUM_SPEEDS'(1) << level;
            ST_EXIT_DELAY:    mode = NUM_SPEEDS'(1);
            default:          mode = '0;
        endcase
        cleaning          = (state == ST_CLEANING);
        countdown         = timed;
        remain_sec        = remain;
        cleaning_reminder = reminder;
    end

endmodule
`default_nettype wire
